ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, a registered response port, and a hardware clear sequence after reset. It replaces the fixed 16×4 storage block of the 4-bit computer. Data width and depth are generic. Reads report completion explicitly, writes never disturb the read output, and memory contents are known (all zero) after every reset.

## Interface
Parameters:
- `DATA_W`, default 4: width of one memory word.
- `ADDR_W`, default 4: address width.
- `DEPTH`, default `1 << ADDR_W`: number of words. Must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: target word.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: `rsp_rdata` holds read data.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  DATA_W: read data, registered.
- `busy`  out  1: clear sequence in progress.

## Operation
- FSM states: CLEAR, RUN.
- Reset (`rst`=1 at an edge):
  - State goes to CLEAR and the clear counter to 0.
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=1, `req_ready`=0.
  - Applies from any state, including mid-clear and with a response pending. A pending response is dropped.
- CLEAR:
  - Writes 0 to `mem[cnt]` and increments `cnt` each cycle.
  - After writing `DEPTH-1`, goes to RUN. Total DEPTH cycles.
  - `req_ready`=0 and `busy`=1 throughout.
- RUN:
  - `req_ready` = !(`rsp_valid` && !`rsp_ready`).
  - A request is accepted when `req_valid` && `req_ready`.
- Write accept: `mem[req_addr]` <= `req_wdata`. `rsp_valid` is not set. `rsp_rdata` is unchanged.
- Read accept: `rsp_rdata` <= `mem[req_addr]` and `rsp_valid` <= 1.
- Response handshake:
  - `rsp_valid` clears on `rsp_valid && rsp_ready` unless a new read is accepted in the same cycle. In that case it stays 1 with the new data.
  - While `rsp_valid`=1 and `rsp_ready`=0, `rsp_rdata` is held stable.
- Address out of range (`req_addr` ≥ DEPTH):
  - Write is ignored.
  - Read returns 0 with `rsp_valid`=1.
  - Only reachable when DEPTH < 2^ADDR_W.
- `req_write`, `req_addr` and `req_wdata` are don't-care when `req_valid`=0.

## Timing
- Read latency: 1 cycle. A read accepted at edge N has `rsp_valid`=1 and data visible after edge N.
- Write to read: a read accepted on the cycle after a write to the same address returns the new data. No same-cycle conflict exists because there is one request per cycle.
- Throughput: 1 request per cycle while `rsp_ready`=1. Back-to-back reads stream without bubbles.
- Clear duration: exactly DEPTH cycles after the edge that samples `rst`=1 then `rst`=0. The first accept is possible on cycle DEPTH+1.
- `req_ready` is combinational from state, `rsp_valid` and `rsp_ready`. There is no path from `req_valid` to `req_ready`.

## Structure
- Package `ram_pkg`: state enum `ram_state_t {CLEAR, RUN}`.
- Sub-module `ram_array`:
  - Plain storage: `DEPTH` × `DATA_W`, one write port and one registered read port.
  - Infers block or distributed RAM.
  - No reset on the storage itself.
- `ram_ctrl` holds the FSM, clear counter (ADDR_W bits), handshake logic and write-port muxing between the clear sequence and requests.

## Test plan
- Reset clear, default parameters: hold `rst` for 2 cycles, release → `busy`=1 for 16 cycles, then `req_ready`=1. Reads of addresses 0–15 all return 0.
- Write then read: write 0xA to addr 3, next cycle read addr 3 → `rsp_valid`=1 one cycle later with `rsp_rdata`=0xA. A subsequent write to addr 3 with 0x5 leaves `rsp_rdata` at 0xA.
- Backpressure: write 0x7 to addr 1, read addr 1 with `rsp_ready`=0 for 3 cycles → `req_ready`=0 and `rsp_rdata`=0x7 held. Raise `rsp_ready` → `rsp_valid` drops and `req_ready`=1 the next cycle.
- Streaming: 16 back-to-back reads with `rsp_ready`=1 → 16 consecutive `rsp_valid` cycles with data in address order.
- Reset mid-operation: assert `rst` with `rsp_valid`=1 and again at clear count 9 → `rsp_valid`=0 and `rsp_rdata`=0 immediately. The full DEPTH-cycle clear restarts from addr 0.
- Parameter sweep: DATA_W=8, ADDR_W=4, DEPTH=12 → clear takes 12 cycles. A write to addr 13 is ignored. A read of addr 13 returns 0 with `rsp_valid`=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the RAM controller.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// Plain DEPTH x DATA_W storage with one write port and one registered read port.
// No reset on the contents, so tools are free to map it onto block or distributed RAM.
module ram_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Request/response front end for ram_array: post-reset zero fill, valid/ready handshakes.
//   state | meaning
//   CLEAR | writing zero to mem[cnt], one word per cycle, no requests taken
//   RUN   | accepting one read or write per cycle, subject to response backpressure
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              zero_q, zero_d;

  logic              mem_we, mem_re, in_range;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, arr_rdata;

  assign in_range = {1'b0, req_addr} < DEPTH_X;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    zero_d      = zero_q;
    busy        = 1'b0;
    req_ready   = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = req_addr;
    mem_wdata   = req_wdata;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        req_ready = !(rsp_valid_q && !rsp_ready);
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (req_valid && req_ready) begin
          if (req_write) begin
            mem_we = in_range;
          end else begin
            // Out-of-range reads skip the array and report zero via the mask flag.
            mem_re      = in_range;
            zero_d      = !in_range;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      zero_q      <= zero_d;
    end
  end

  ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .raddr_i(req_addr),
    .rdata_o(arr_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  // The array read register has no reset; zero_q masks it until a real read lands.
  assign rsp_rdata = zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: default 16x4 instance plus a 12x8 instance with a sparse map.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, busy;
  logic [3:0] req_addr, req_wdata, rsp_rdata;

  logic       p_rst, p_req_valid, p_req_ready, p_req_write, p_rsp_valid, p_rsp_ready, p_busy;
  logic [3:0] p_req_addr;
  logic [7:0] p_req_wdata, p_rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  ram_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  ram_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut_p (
    .clk(clk), .rst(p_rst), .req_valid(p_req_valid), .req_ready(p_req_ready),
    .req_write(p_req_write), .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_rdata(p_rsp_rdata), .busy(p_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int exp_n, input string name);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    n_cmp++;
    if (n !== exp_n) begin
      n_err++;
      $display("FAIL %s: busy cycles got %0d want %0d", name, n, exp_n);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready: req_ready got %b want 1", name, req_ready);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] exp_d, input string name);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
      n_err++;
      $display("FAIL %s addr %0d: valid/data got %b/%h want 1/%h", name, a, rsp_valid, rsp_rdata, exp_d);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: busy/ready/valid/data got %b/%b/%b/%h want 1/0/0/0",
               busy, req_ready, rsp_valid, rsp_rdata);
    end
    rst = 1'b0;
    count_busy(16, "reset_clear");
    for (int i = 0; i < 16; i++) do_read(4'(i), 4'h0, "cleared_read");
  endtask

  task automatic test_write_read;
    step();
    do_write(4'd3, 4'hA);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL write_no_rsp: rsp_valid got %b want 0", rsp_valid);
    end
    do_read(4'd3, 4'hA, "write_then_read");
    do_write(4'd3, 4'h5);
    n_cmp++;
    if (rsp_rdata !== 4'hA || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL write_keeps_rdata: valid/data got %b/%h want 0/a", rsp_valid, rsp_rdata);
    end
    do_read(4'd3, 4'h5, "overwrite_read");
  endtask

  task automatic test_backpressure;
    step();
    do_write(4'd1, 4'h7);
    rsp_ready = 1'b0;
    do_read(4'd1, 4'h7, "bp_first");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 4'h7) begin
        n_err++;
        $display("FAIL bp_hold cyc %0d: ready/valid/data got %b/%b/%h want 0/1/7",
                 i, req_ready, rsp_valid, rsp_rdata);
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid/ready got %b/%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) do_write(4'(i), 4'(15 - i));
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_addr = 4'(i);
      step();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'(15 - i)) begin
        n_err++;
        $display("FAIL stream addr %0d: valid/data got %b/%h want 1/%h", i, rsp_valid, rsp_rdata, 4'(15 - i));
      end
    end
    req_valid = 1'b0;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    rsp_ready = 1'b0;
    do_read(4'd5, 4'hA, "pre_reset_read");
    rst = 1'b1;
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 4'h0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drop_rsp: valid/data/busy/ready got %b/%h/%b/%b want 0/0/1/0",
               rsp_valid, rsp_rdata, busy, req_ready);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (9) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_clear_busy: busy got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(16, "restart_clear");
    do_read(4'd0, 4'h0, "reclear_read");
    do_read(4'd5, 4'h0, "reclear_read");
    do_read(4'd12, 4'h0, "reclear_read");
    do_read(4'd15, 4'h0, "reclear_read");
  endtask

  task automatic p_access(input logic wr, input logic [3:0] a, input logic [7:0] d);
    p_req_valid = 1'b1; p_req_write = wr; p_req_addr = a; p_req_wdata = d;
    step();
    p_req_valid = 1'b0;
  endtask

  task automatic test_param_sweep;
    int n = 0;
    p_rst = 1'b1;
    step();
    p_rst = 1'b0;
    while (p_busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    n_cmp++;
    if (n !== 12) begin
      n_err++;
      $display("FAIL p_clear: busy cycles got %0d want 12", n);
    end
    p_access(1'b1, 4'd13, 8'hAB);
    p_access(1'b1, 4'd11, 8'h5C);
    p_access(1'b0, 4'd13, 8'h00);
    n_cmp++;
    if (p_rsp_valid !== 1'b1 || p_rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL p_oor_read: valid/data got %b/%h want 1/00", p_rsp_valid, p_rsp_rdata);
    end
    p_access(1'b0, 4'd11, 8'h00);
    n_cmp++;
    if (p_rsp_valid !== 1'b1 || p_rsp_rdata !== 8'h5C) begin
      n_err++;
      $display("FAIL p_last_read: valid/data got %b/%h want 1/5c", p_rsp_valid, p_rsp_rdata);
    end
    p_access(1'b0, 4'd13, 8'h00);
    n_cmp++;
    if (p_rsp_valid !== 1'b1 || p_rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL p_oor_after: valid/data got %b/%h want 1/00", p_rsp_valid, p_rsp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    p_rst = 1'b1; p_req_valid = 1'b0; p_req_write = 1'b0; p_req_addr = '0; p_req_wdata = '0;
    p_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
